serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Digit-serial modulo-2^WIDTH subtractor: o_diff = i_a - i_b.
- Arithmetic inverse of the adder chain. The datapath recovers an operand from a sum, e.g. a = sum - b, for round-state rollback and self-check.
- Processes DIGIT bits per clock through a ripple borrow chain of DIGIT full-subtractor cells, with the borrow kept in a flop between cycles.
- Valid/ready handshake on input and output. Sits beside the adder datapath in the SHA-256 core.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Must satisfy DIGIT >= 1 and WIDTH % DIGIT == 0; otherwise elaboration fails.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  minuend.
- i_b  input  WIDTH  subtrahend.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_diff  output  WIDTH  (i_a - i_b) mod 2^WIDTH.

Behaviour:
- Reset (asynchronous, active-high) forces the following, regardless of clock:
  - state = IDLE, o_ready = 1, o_valid = 0, o_diff = 0.
  - borrow flop = 0, digit counter = 0, operand shift registers = 0.
- Constant: N = WIDTH/DIGIT (default 8).
- IDLE:
  - o_ready = 1.
  - On i_valid && o_ready at a rising edge: capture i_a and i_b into shift registers, clear borrow, counter = 0, go to RUN.
- RUN:
  - o_ready = 0. i_valid is ignored and no new capture occurs.
  - Each cycle, the low DIGIT bits of A and B feed the cell chain. Per cell: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
  - The DIGIT result bits shift into the MSB end of the result register. A and B shift right by DIGIT. The final bout is stored in the borrow flop.
  - After the N-th digit (counter == N-1), go to DONE.
- DONE:
  - o_valid = 1; o_diff holds the full result, stable until the handshake.
  - On i_valid-independent i_ready && o_valid: o_valid = 0, go to IDLE.
  - Without i_ready, hold indefinitely. o_diff and the final borrow do not change.
- Latency: o_valid rises exactly N cycles after the accepting edge (8 cycles at defaults).
- Throughput: minimum N+2 cycles per operation. No back-to-back acceptance in DONE.
- o_diff remains at its last value in IDLE and RUN. Consumers sample it only while o_valid = 1.
- Wrap-around: the result is modulo 2^WIDTH; an underflow produces the two's-complement value with no error indication.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; the result is discarded. After release, the first edge with i_valid starts a fresh operation.
- DIGIT = WIDTH degenerates to a single-cycle RUN (N = 1); all rules still hold.

Optional Feature:
- Macro: SERIAL_SUB_BORROW_OUT_EN.
- Defined: adds port o_borrow (output, 1 bit).
  - Equals the final borrow of the operation; 1 when i_a < i_b, unsigned.
  - Valid only while o_valid = 1 and held with o_diff. Reset value 0.
- Undefined: the port is absent; the final borrow flop value is unobservable. Results are otherwise identical.

Test Plan:
- Basic subtraction: reset, then i_a = 5, i_b = 3 accepted -> o_valid exactly 8 cycles later, o_diff = 0x00000002, o_borrow = 0.
- Underflow: i_a = 0x00000000, i_b = 0x00000001 -> o_diff = 0xFFFFFFFF, o_borrow = 1 (macro defined).
- Borrow across every digit boundary: i_a = 0x80000000, i_b = 0x7FFFFFFF -> o_diff = 0x00000001. Also i_a = i_b = 0xDEADBEEF -> o_diff = 0.
- Backpressure: hold i_ready = 0 for 20 cycles in DONE -> o_valid stays 1, o_diff is stable, o_ready stays 0. Raise i_ready -> IDLE next cycle, o_ready = 1.
- Busy input ignored: drive i_valid with new operands every cycle during RUN -> result equals the first operands only. The second operation starts only after return to IDLE.
- Reset mid-operation: assert i_rst asynchronously at digit 4 -> o_valid = 0, o_ready = 1 immediately. Then 9 - 4 completes with o_diff = 5. Repeat with DIGIT = 1 (32 cycles) and DIGIT = 32 (1 cycle).

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial (i_a - i_b) mod 2^WIDTH, DIGIT bits per clock, valid/ready on both sides.
// Define SERIAL_SUB_BORROW_OUT_EN to expose the final borrow (i_a < i_b) on o_borrow.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef SERIAL_SUB_BORROW_OUT_EN
  output logic             o_borrow,
`endif
  output logic [WIDTH-1:0] o_diff
);

  localparam int N  = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
    $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] digitDiff;
  logic             borrowOut;
  logic [WIDTH-1:0] resShift;

  // Ripple borrow chain over the low DIGIT bits of the operand shift registers.
  always_comb begin
    logic brw;
    brw       = borrow_q;
    digitDiff = '0;
    for (int i = 0; i < DIGIT; i++) begin
      digitDiff[i] = a_q[i] ^ b_q[i] ^ brw;
      brw          = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & brw);
    end
    borrowOut = brw;
  end

  // New digits enter at the MSB end so the LSB digit ends up at bit 0 after N steps.
  assign resShift = (res_q >> DIGIT) | (WIDTH'(digitDiff) << (WIDTH - DIGIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          a_d      = i_a;
          b_d      = i_b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = resShift;
        borrow_d = borrowOut;
        // o_diff only updates once the whole word is assembled.
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = resShift;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_diff = diff_q;
`ifdef SERIAL_SUB_BORROW_OUT_EN
  assign o_borrow = borrow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: DIGIT = 4, 1 and 32 instances share one stimulus stream and
// each keeps its own queue of expected results and acceptance cycles.
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic        iReady;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        oReady [3];
  logic        oValid [3];
  logic [31:0] oDiff  [3];
`ifdef SERIAL_SUB_BORROW_OUT_EN
  logic        oBorrow [3];
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] cyc         = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gInst
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    localparam int NG = 32 / DG;

    typedef struct packed {
      logic [31:0] diff;
      logic        brw;
      logic [31:0] cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t head;
    exp_t entry;
    logic prevValid  = 1'b0;
    int   pendingNow = 0;

    serial_subtractor #(.WIDTH(32), .DIGIT(DG)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (iValid),
      .o_ready (oReady[g]),
      .i_a     (iA),
      .i_b     (iB),
      .o_valid (oValid[g]),
      .i_ready (iReady),
`ifdef SERIAL_SUB_BORROW_OUT_EN
      .o_borrow(oBorrow[g]),
`endif
      .o_diff  (oDiff[g])
    );

    // Sampled on the falling edge, halfway between the edges that act on these values.
    always @(negedge clk) begin
      if (rst) begin
        expQ.delete();
        prevValid = 1'b0;
      end else begin
        if (oValid[g] && !prevValid) begin
          if (expQ.size() == 0)
            checkOutput($sformatf("spurious_valid_d%0d", DG), {31'b0, oValid[g]}, 32'd0);
          else
            checkOutput($sformatf("latency_d%0d", DG), cyc - expQ[0].cyc, 32'(NG));
        end
        if (oValid[g] && iReady) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("spurious_out_d%0d", DG), {31'b0, oValid[g]}, 32'd0);
          end else begin
            head = expQ.pop_front();
            checkOutput($sformatf("diff_d%0d", DG), oDiff[g], head.diff);
`ifdef SERIAL_SUB_BORROW_OUT_EN
            checkOutput($sformatf("borrow_d%0d", DG), {31'b0, oBorrow[g]}, {31'b0, head.brw});
`endif
          end
        end
        if (iValid && oReady[g]) begin
          entry.diff = iA - iB;
          entry.brw  = (iA < iB);
          entry.cyc  = cyc + 32'd1;
          expQ.push_back(entry);
        end
        prevValid = oValid[g];
      end
      pendingNow = expQ.size();
    end
  end

  task automatic waitAllReady();
    int budget = 0;
    while (!(oReady[0] && oReady[1] && oReady[2]) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200)
      checkOutput("ready_timeout", {31'b0, oReady[0] && oReady[1] && oReady[2]}, 32'd1);
  endtask

  task automatic waitAllValid();
    int budget = 0;
    while (!(oValid[0] && oValid[1] && oValid[2]) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200)
      checkOutput("valid_timeout", {31'b0, oValid[0] && oValid[1] && oValid[2]}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    waitAllReady();
    iA     = a;
    iB     = b;
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  initial begin
    logic [31:0] bpA;
    logic [31:0] bpB;
    rst    = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iA     = '0;
    iB     = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_ready_%0d", k), {31'b0, oReady[k]}, 32'd1);
      checkOutput($sformatf("rst_valid_%0d", k), {31'b0, oValid[k]}, 32'd0);
      checkOutput($sformatf("rst_diff_%0d", k), oDiff[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(32'd5, 32'd3);
    applyStimulus(32'h0000_0000, 32'h0000_0001);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF);
    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // New operands every cycle while busy; the DIGIT=4 unit must take only the first.
    waitAllReady();
    iA     = 32'h0000_1000;
    iB     = 32'h0000_0234;
    iValid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checkOutput("busy_ready_d4", {31'b0, oReady[0]}, 32'd0);
      iA = $urandom;
      iB = $urandom;
    end
    iValid = 1'b0;
    applyStimulus(32'h0000_0010, 32'h0000_0020);

    bpA    = 32'h1234_5678;
    bpB    = 32'h0000_0079;
    waitAllReady();
    iReady = 1'b0;
    applyStimulus(bpA, bpB);
    waitAllValid();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("bp_valid_%0d", k), {31'b0, oValid[k]}, 32'd1);
        checkOutput($sformatf("bp_diff_%0d", k), oDiff[k], bpA - bpB);
        checkOutput($sformatf("bp_ready_%0d", k), {31'b0, oReady[k]}, 32'd0);
`ifdef SERIAL_SUB_BORROW_OUT_EN
        checkOutput($sformatf("bp_borrow_%0d", k), {31'b0, oBorrow[k]}, 32'd0);
`endif
      end
    end
    iReady = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_release_ready_%0d", k), {31'b0, oReady[k]}, 32'd1);
      checkOutput($sformatf("bp_release_valid_%0d", k), {31'b0, oValid[k]}, 32'd0);
      checkOutput($sformatf("bp_hold_diff_%0d", k), oDiff[k], bpA - bpB);
    end

    // Asynchronous reset after four digits of the DIGIT=4 operation.
    applyStimulus(32'h0000_0100, 32'h0000_0001);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("abort_valid_%0d", k), {31'b0, oValid[k]}, 32'd0);
      checkOutput($sformatf("abort_ready_%0d", k), {31'b0, oReady[k]}, 32'd1);
      checkOutput($sformatf("abort_diff_%0d", k), oDiff[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(32'd9, 32'd4);

    for (int r = 0; r < 5; r++) begin
      applyStimulus($urandom, $urandom);
    end

    waitAllReady();
    @(posedge clk); #1;
    checkOutput("pending_d4", 32'(gInst[0].pendingNow), 32'd0);
    checkOutput("pending_d1", 32'(gInst[1].pendingNow), 32'd0);
    checkOutput("pending_d32", 32'(gInst[2].pendingNow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
